// File: rtl/boreal_adc_frame_reader.sv
// boreal_adc_frame_reader
//   SPI master (mode 1) for the 8-channel, 24-bit ECG ADC front-end. Each
//   data-ready falling edge triggers one 216-bit frame read: a 24-bit status
//   word followed by eight 24-bit channel words. Frames whose status nibble is
//   4'b1100 are latched into raw8 and announced with eight adc_valid strobes
//   (ch = 0..7). Frames with a bad header pulse frame_err instead.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   en           frame acquisition enable, only looked at while idle
//   drdy_n       ADC data-ready, active-low, asynchronous
//   spi_miso     ADC serial data, asynchronous
//   spi_sclk     SPI clock, idles low
//   spi_cs_n     ADC chip select, active-low
//   raw8         latched channel data, channel k at [k*24 +: 24]
//   adc_valid    one-cycle strobe per channel
//   ch           channel index qualified by adc_valid (holds between strobes)
//   frame_err    one-cycle pulse on a bad status header
//   overrun_cnt  saturating count of drdy events that arrived while busy
//   busy         high whenever the reader is not idle
module boreal_adc_frame_reader #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int EMIT_GAP = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         drdy_n,
  input  logic         spi_miso,
  output logic         spi_sclk,
  output logic         spi_cs_n,
  output logic [191:0] raw8,
  output logic         adc_valid,
  output logic [2:0]   ch,
  output logic         frame_err,
  output logic [7:0]   overrun_cnt,
  output logic         busy
);

  localparam int FRAME_BITS = 216;
  localparam int CH_BITS    = 24;
  localparam int NUM_CH     = 8;
  localparam int DATA_BITS  = CH_BITS * NUM_CH;
  localparam int CNT_W      = 16;

  // miso is sampled CLK_DIV cycles after the rising SCLK edge that launched
  // it; the two-flop synchroniser eats two of those cycles.
  generate
    if (CLK_DIV < 3 || CS_SETUP < 1 || CS_HOLD < 1 || EMIT_GAP < 0) begin : g_param_check
      $error("boreal_adc_frame_reader: CLK_DIV must be >= 3, CS_SETUP/CS_HOLD >= 1, EMIT_GAP >= 0");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_CHECK,
    ST_EMIT
  } state_t;

  state_t                 state_reg, state_next;
  logic                   drdy_meta_reg, drdy_sync_reg, drdy_prev_reg;
  logic                   miso_meta_reg, miso_sync_reg;
  logic                   sclk_reg, sclk_next;
  logic                   cs_n_reg, cs_n_next;
  logic [3:0]             status_reg, status_next;
  logic [DATA_BITS-1:0]   data_reg, data_next;
  logic [7:0]             bit_cnt_reg, bit_cnt_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [DATA_BITS-1:0]   raw8_reg, raw8_next;
  logic                   adc_valid_reg, adc_valid_next;
  logic [2:0]             ch_reg, ch_next;
  logic                   frame_err_reg, frame_err_next;
  logic [7:0]             overrun_reg, overrun_next;
  logic                   drdy_fall;
  logic [DATA_BITS-1:0]   frame_ch;

  assign drdy_fall = drdy_prev_reg & ~drdy_sync_reg;

  // Only the status nibble is kept; the remaining 20 status bits pass through
  // data_reg and are pushed out the top by the 192 channel bits behind them.
  // The first channel word received ends up at the top of data_reg and is
  // remapped so channel 0 lands in the low slice of raw8.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch_map
      assign frame_ch[gi*CH_BITS +: CH_BITS] = data_reg[(NUM_CH-1-gi)*CH_BITS +: CH_BITS];
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    sclk_next      = sclk_reg;
    cs_n_next      = cs_n_reg;
    status_next    = status_reg;
    data_next      = data_reg;
    bit_cnt_next   = bit_cnt_reg;
    cnt_next       = cnt_reg;
    raw8_next      = raw8_reg;
    adc_valid_next = 1'b0;
    ch_next        = ch_reg;
    frame_err_next = 1'b0;
    overrun_next   = overrun_reg;

    if (drdy_fall && state_reg != ST_IDLE && overrun_reg != 8'hFF) begin
      overrun_next = overrun_reg + 8'd1;
    end

    case (state_reg)
      ST_IDLE: begin
        if (drdy_fall && en) begin
          state_next = ST_SETUP;
          cs_n_next  = 1'b0;
          cnt_next   = '0;
        end
      end
      ST_SETUP: begin
        if (cnt_reg == CNT_W'(CS_SETUP - 1)) begin
          state_next   = ST_SHIFT;
          sclk_next    = 1'b1;
          cnt_next     = '0;
          bit_cnt_next = '0;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      ST_SHIFT: begin
        if (cnt_reg == CNT_W'(CLK_DIV - 1)) begin
          cnt_next = '0;
          if (sclk_reg) begin
            // falling edge: capture the bit launched on the preceding rise
            sclk_next = 1'b0;
            data_next = {data_reg[DATA_BITS-2:0], miso_sync_reg};
            if (bit_cnt_reg < 8'd4) begin
              status_next = {status_reg[2:0], miso_sync_reg};
            end
          end else if (bit_cnt_reg == 8'(FRAME_BITS - 1)) begin
            // last bit's low phase finished: no further rising edge
            state_next = ST_HOLD;
          end else begin
            sclk_next    = 1'b1;
            bit_cnt_next = bit_cnt_reg + 8'd1;
          end
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_reg == CNT_W'(CS_HOLD - 1)) begin
          state_next = ST_CHECK;
          cs_n_next  = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      ST_CHECK: begin
        if (status_reg == 4'b1100) begin
          raw8_next      = frame_ch;
          state_next     = ST_EMIT;
          adc_valid_next = 1'b1;
          ch_next        = 3'd0;
          cnt_next       = '0;
        end else begin
          frame_err_next = 1'b1;
          state_next     = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (adc_valid_reg) begin
          if (ch_reg == 3'd7) begin
            state_next = ST_IDLE;
          end else if (EMIT_GAP == 0) begin
            adc_valid_next = 1'b1;
            ch_next        = ch_reg + 3'd1;
          end else begin
            cnt_next = '0;
          end
        end else if (cnt_reg == CNT_W'(EMIT_GAP - 1)) begin
          adc_valid_next = 1'b1;
          ch_next        = ch_reg + 3'd1;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      drdy_meta_reg <= 1'b1;
      drdy_sync_reg <= 1'b1;
      drdy_prev_reg <= 1'b1;
      miso_meta_reg <= 1'b1;
      miso_sync_reg <= 1'b1;
      sclk_reg      <= 1'b0;
      cs_n_reg      <= 1'b1;
      status_reg    <= '0;
      data_reg      <= '0;
      bit_cnt_reg   <= '0;
      cnt_reg       <= '0;
      raw8_reg      <= '0;
      adc_valid_reg <= 1'b0;
      ch_reg        <= 3'd0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 8'd0;
    end else begin
      state_reg     <= state_next;
      drdy_meta_reg <= drdy_n;
      drdy_sync_reg <= drdy_meta_reg;
      drdy_prev_reg <= drdy_sync_reg;
      miso_meta_reg <= spi_miso;
      miso_sync_reg <= miso_meta_reg;
      sclk_reg      <= sclk_next;
      cs_n_reg      <= cs_n_next;
      status_reg    <= status_next;
      data_reg      <= data_next;
      bit_cnt_reg   <= bit_cnt_next;
      cnt_reg       <= cnt_next;
      raw8_reg      <= raw8_next;
      adc_valid_reg <= adc_valid_next;
      ch_reg        <= ch_next;
      frame_err_reg <= frame_err_next;
      overrun_reg   <= overrun_next;
    end
  end

  assign spi_sclk    = sclk_reg;
  assign spi_cs_n    = cs_n_reg;
  assign raw8        = raw8_reg;
  assign adc_valid   = adc_valid_reg;
  assign ch          = ch_reg;
  assign frame_err   = frame_err_reg;
  assign overrun_cnt = overrun_reg;
  assign busy        = (state_reg != ST_IDLE);

endmodule
